// File: rtl/global_mem_arbiter_pkg.sv
// Shared definitions for the global memory arbiter: bus widths, core count
// default, FSM state encoding and an index-width helper.
package global_mem_arbiter_pkg;

    localparam int GMEM_ADDR_WIDTH = 32;
    localparam int GMEM_DATA_WIDTH = 32;
    localparam int GMEM_NUM_CORES  = 4;

    // Arbiter FSM: wait for work, drive the one-cycle request, wait for ack.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } gmem_state_e;

    // Width of an index into n entries; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/global_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the lowest pending
// index at or after i_rr_ptr, wrapping from num_cores-1 back to 0.
module rr_picker
    import global_mem_arbiter_pkg::*;
#(
    parameter int num_cores = GMEM_NUM_CORES
) (
    input  logic [num_cores-1:0]                 i_pending,
    input  logic [idx_width(num_cores)-1:0]      i_rr_ptr,
    output logic [idx_width(num_cores)-1:0]      o_grant,
    output logic                                 o_any_valid
);

    localparam int PW = idx_width(num_cores);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    // Scan from the pointer upward, first pending entry wins.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop so no path leaves it unassigned, which would otherwise infer a latch.
        o_grant     = '0;
        o_any_valid = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < num_cores; k++) begin
            // NOTE: blocking assignments here are intentional -- w_sum/w_idx are scratch values reused within the same pass of the loop.
            w_sum = {1'b0, i_rr_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(num_cores)) begin
                w_sum = w_sum - (PW+1)'(num_cores);
            end
            w_idx = w_sum[PW-1:0];
            if (!o_any_valid && i_pending[w_idx]) begin
                o_any_valid = 1'b1;
                o_grant     = w_idx;
            end
        end
    end

endmodule

// File: rtl/global_mem_arbiter.sv
// global_mem_arbiter: shares one memory port among num_cores requesters.
// Each core owns a single request slot; a round-robin FSM issues one slot
// at a time and returns read data / ack to the owning core.
module global_mem_arbiter
    import global_mem_arbiter_pkg::*;
#(
    parameter int num_cores  = GMEM_NUM_CORES,
    parameter int addr_width = GMEM_ADDR_WIDTH,
    parameter int data_width = GMEM_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    // core side
    input  logic [num_cores*addr_width-1:0]  core_addr,
    input  logic [num_cores-1:0]             core_rd_req,
    input  logic [num_cores-1:0]             core_wr_req,
    input  logic [num_cores*data_width-1:0]  core_wr_data,
    output logic [num_cores*data_width-1:0]  core_rd_data,
    output logic [num_cores-1:0]             core_busy,
    output logic [num_cores-1:0]             core_ack,
    output logic [num_cores-1:0]             err_dup,
    // memory side
    output logic [addr_width-1:0]            mem_addr,
    output logic                             mem_rd_req,
    output logic                             mem_wr_req,
    output logic [data_width-1:0]            mem_wr_data,
    input  logic [data_width-1:0]            mem_rd_data,
    input  logic                             mem_busy,
    input  logic                             mem_ack
);

    localparam int PW = idx_width(num_cores);

    // request slots
    logic [num_cores-1:0]  r_pend;
    logic [num_cores-1:0]  r_slot_wr;
    logic [addr_width-1:0] r_slot_addr [num_cores];
    logic [data_width-1:0] r_slot_data [num_cores];
    logic [num_cores-1:0]  r_err_dup;

    // arbiter state
    gmem_state_e           r_state;
    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         r_owner;
    logic                  r_mem_rd_req;
    logic                  r_mem_wr_req;
    logic [addr_width-1:0] r_mem_addr;
    logic [data_width-1:0] r_mem_wr_data;
    logic [num_cores-1:0]  r_core_ack;
    logic [data_width-1:0] r_rd_data [num_cores];

    logic [num_cores-1:0]  w_req;
    logic [num_cores-1:0]  w_accept;
    logic [num_cores-1:0]  w_dup;
    logic [num_cores-1:0]  w_ack_clr;
    logic [PW-1:0]         w_grant;
    logic                  w_any_valid;
    logic                  w_start;
    logic [PW-1:0]         w_next_ptr;

    assign w_req    = core_rd_req | core_wr_req;
    // A request only lands in an empty slot; anything else is a protocol error.
    assign w_accept = w_req & ~r_pend;
    assign w_dup    = w_req & (r_pend | (core_rd_req & core_wr_req));
    assign w_start  = (r_state == ST_IDLE) && w_any_valid && !mem_busy;
    assign w_next_ptr = (r_owner == PW'(num_cores - 1)) ? '0 : r_owner + 1'b1;

    rr_picker #(
        .num_cores (num_cores)
    ) u_rr_picker (
        .i_pending   (r_pend),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_any_valid (w_any_valid)
    );

    // Decode which slot completes at this edge (owner, WAIT state, mem_ack).
    always_comb begin
        w_ack_clr = '0;
        if (r_state == ST_WAIT && mem_ack) begin
            w_ack_clr[r_owner] = 1'b1;
        end
    end

    // Slot occupancy, direction and sticky duplicate-request flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend    <= '0;
            r_slot_wr <= '0;
            r_err_dup <= '0;
        end else begin
            for (int i = 0; i < num_cores; i++) begin
                if (w_ack_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_pend[i]    <= 1'b1;
                    r_slot_wr[i] <= core_wr_req[i];
                end
                if (w_dup[i]) begin
                    r_err_dup[i] <= 1'b1;
                end
            end
        end
    end

    // Slot payload capture when a request is accepted.
    // NOTE: the payload array has no reset; it is only ever read while r_pend marks it valid, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < num_cores; i++) begin
            if (w_accept[i]) begin
                r_slot_addr[i] <= core_addr[i*addr_width +: addr_width];
                r_slot_data[i] <= core_wr_data[i*data_width +: data_width];
            end
        end
    end

    // Arbiter FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_mem_rd_req  <= 1'b0;
            r_mem_wr_req  <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_core_ack    <= '0;
            for (int i = 0; i < num_cores; i++) begin
                r_rd_data[i] <= '0;
            end
        end else begin
            r_core_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state       <= ST_ISSUE;
                        r_owner       <= w_grant;
                        r_mem_addr    <= r_slot_addr[w_grant];
                        r_mem_wr_data <= r_slot_data[w_grant];
                        r_mem_wr_req  <= r_slot_wr[w_grant];
                        r_mem_rd_req  <= !r_slot_wr[w_grant];
                    end
                end
                ST_ISSUE: begin
                    r_state      <= ST_WAIT;
                    r_mem_rd_req <= 1'b0;
                    r_mem_wr_req <= 1'b0;
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        r_state             <= ST_IDLE;
                        r_core_ack[r_owner] <= 1'b1;
                        r_rr_ptr            <= w_next_ptr;
                        if (!r_slot_wr[r_owner]) begin
                            r_rd_data[r_owner] <= mem_rd_data;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_busy   = r_pend;
    assign core_ack    = r_core_ack;
    assign err_dup     = r_err_dup;
    assign mem_addr    = r_mem_addr;
    assign mem_rd_req  = r_mem_rd_req;
    assign mem_wr_req  = r_mem_wr_req;
    assign mem_wr_data = r_mem_wr_data;

    for (genvar g = 0; g < num_cores; g++) begin : g_rd_out
        assign core_rd_data[g*data_width +: data_width] = r_rd_data[g];
    end

endmodule

// File: tb/tb_global_mem_arbiter.sv
// Directed bench for global_mem_arbiter: reset, single read, simultaneous
// writes, fairness, mem_busy stall, protocol errors and reset mid-WAIT.
module tb_global_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk;
    logic             rst;
    logic [NC*AW-1:0] core_addr;
    logic [NC-1:0]    core_rd_req;
    logic [NC-1:0]    core_wr_req;
    logic [NC*DW-1:0] core_wr_data;
    logic [NC*DW-1:0] core_rd_data;
    logic [NC-1:0]    core_busy;
    logic [NC-1:0]    core_ack;
    logic [NC-1:0]    err_dup;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd_req;
    logic             mem_wr_req;
    logic [DW-1:0]    mem_wr_data;
    logic [DW-1:0]    mem_rd_data;
    logic             mem_busy;
    logic             mem_ack;
    logic             mem_ack_auto;
    logic             mem_ack_man;

    assign mem_ack = mem_ack_auto | mem_ack_man;

    int n_vec = 0;
    int n_err = 0;

    global_mem_arbiter #(
        .num_cores  (NC),
        .addr_width (AW),
        .data_width (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_addr    (core_addr),
        .core_rd_req  (core_rd_req),
        .core_wr_req  (core_wr_req),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_busy    (core_busy),
        .core_ack     (core_ack),
        .err_dup      (err_dup),
        .mem_addr     (mem_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_busy     (mem_busy),
        .mem_ack      (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: log each issued request, ack mem_lat cycles later.
    // Read data for address a is 0xDEADBEAF ^ a.
    bit            auto_resp = 1'b0;
    int            mem_lat   = 3;
    int            lat_cnt   = 0;
    logic [AW-1:0] pend_addr;
    logic [AW-1:0] iss_addr [$];
    logic          iss_wr   [$];
    logic [DW-1:0] iss_data [$];

    initial begin
        mem_ack_auto = 1'b0;
        mem_rd_data  = '0;
        pend_addr    = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_auto = 1'b0;
            if (!auto_resp) begin
                lat_cnt = 0;
            end else if (lat_cnt == 0) begin
                if (mem_rd_req || mem_wr_req) begin
                    iss_addr.push_back(mem_addr);
                    iss_wr.push_back(mem_wr_req);
                    iss_data.push_back(mem_wr_data);
                    pend_addr = mem_addr;
                    lat_cnt   = mem_lat;
                end
            end else begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_ack_auto = 1'b1;
                    mem_rd_data  = 32'hDEADBEAF ^ pend_addr;
                end
            end
        end
    end

    // Count completion pulses on the falling edge, away from the active edge.
    int ack_total = 0;
    always @(negedge clk) ack_total += $countones(core_ack);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_addr[i*AW +: AW]    = a;
        core_wr_data[i*DW +: DW] = d;
        core_rd_req[i]           = rd;
        core_wr_req[i]           = wr;
    endtask

    task automatic clear_req();
        core_rd_req = '0;
        core_wr_req = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Step until core i acks (bounded); n = number of steps taken.
    task automatic wait_ack(input int i, output int n);
        n = 0;
        while (core_ack[i] !== 1'b1 && n < 60) begin
            step();
            n++;
        end
    endtask

    // Step until every slot is empty (bounded), then one more so the ack is counted.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (core_busy !== '0 && n < 300) begin
            step();
            n++;
        end
        check(tag, (n < 300), 1'b1);
        step();
    endtask

    function automatic logic [DW-1:0] rd_of(input int i);
        return core_rd_data[i*DW +: DW];
    endfunction

    int base;
    int ack0;
    int lat;

    initial begin
        rst          = 1'b0;
        core_addr    = '0;
        core_wr_data = '0;
        core_rd_req  = '0;
        core_wr_req  = '0;
        mem_busy     = 1'b0;
        mem_ack_man  = 1'b0;
        step();
        step();

        // ---- reset state
        check("rst_busy",     core_busy,    4'h0);
        check("rst_ack",      core_ack,     4'h0);
        check("rst_err",      err_dup,      4'h0);
        check("rst_rdreq",    mem_rd_req,   1'b0);
        check("rst_wrreq",    mem_wr_req,   1'b0);
        check("rst_addr",     mem_addr,     32'h0);
        check("rst_wdata",    mem_wr_data,  32'h0);
        check("rst_rdata",    core_rd_data, 128'h0);
        rst       = 1'b1;
        auto_resp = 1'b1;
        step();

        // ---- single read: core0 reads 0x40, memory acks after 3 cycles
        mem_lat = 3;
        ack0    = ack_total;
        set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        clear_req();
        check("rd1_busy",     core_busy,  4'b0001);
        check("rd1_noreq",    mem_rd_req, 1'b0);
        step();
        check("rd1_issue",    mem_rd_req, 1'b1);
        check("rd1_wrreq",    mem_wr_req, 1'b0);
        check("rd1_addr",     mem_addr,   32'h40);
        step();
        check("rd1_req_drop", mem_rd_req, 1'b0);
        check("rd1_addr_hold", mem_addr,  32'h40);
        wait_ack(0, lat);
        check("rd1_latency",  lat,        3);
        check("rd1_data",     rd_of(0),   32'hDEADBEEF);
        check("rd1_busy_low", core_busy,  4'b0000);
        step();
        check("rd1_ack_pulse", core_ack,  4'b0000);
        check("rd1_ack_cnt",  ack_total - ack0, 1);

        // ---- simultaneous writes from all cores, two rounds
        do_reset();
        mem_lat = 2;
        for (int r = 0; r < 2; r++) begin
            base = iss_addr.size();
            ack0 = ack_total;
            for (int i = 0; i < NC; i++) begin
                set_req(i, 1'b0, 1'b1, 32'h100 + 32'(r*16 + i*4), 32'h1000 + 32'(r*16 + i));
            end
            step();
            clear_req();
            wait_idle($sformatf("wr%0d_done", r));
            check($sformatf("wr%0d_count", r), iss_addr.size() - base, 4);
            for (int k = 0; k < NC; k++) begin
                check($sformatf("wr%0d_addr%0d", r, k), iss_addr[base+k], 32'h100 + 32'(r*16 + k*4));
                check($sformatf("wr%0d_dir%0d",  r, k), iss_wr[base+k],   1'b1);
                check($sformatf("wr%0d_data%0d", r, k), iss_data[base+k], 32'h1000 + 32'(r*16 + k));
            end
            check($sformatf("wr%0d_acks", r), ack_total - ack0, 4);
        end
        check("wr_rdata_kept", core_rd_data, 128'h0);

        // ---- fairness: core0 re-requests in each ack cycle while core2 waits
        do_reset();
        base = iss_addr.size();
        ack0 = ack_total;
        set_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h300, 32'h0);
        step();
        clear_req();
        wait_ack(0, lat);
        set_req(0, 1'b1, 1'b0, 32'h204, 32'h0);
        step();
        clear_req();
        wait_ack(0, lat);
        set_req(0, 1'b1, 1'b0, 32'h20C, 32'h0);
        step();
        clear_req();
        wait_idle("fair_done");
        check("fair_ord0", iss_addr[base+0], 32'h200);
        check("fair_ord1", iss_addr[base+1], 32'h300);
        check("fair_ord2", iss_addr[base+2], 32'h204);
        check("fair_ord3", iss_addr[base+3], 32'h20C);
        check("fair_acks", ack_total - ack0, 4);
        check("fair_rd2",  rd_of(2), 32'hDEADBDAF);
        check("fair_rd0",  rd_of(0), 32'hDEADBCA3);
        check("fair_err",  err_dup,  4'b0000);

        // ---- mem_busy holds off issue for 5 cycles
        do_reset();
        mem_busy = 1'b1;
        set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
        step();
        clear_req();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mbusy_hold%0d", k), mem_rd_req, 1'b0);
            step();
        end
        check("mbusy_hold4", mem_rd_req, 1'b0);
        mem_busy = 1'b0;
        step();
        check("mbusy_issue", mem_rd_req, 1'b1);
        check("mbusy_addr",  mem_addr,   32'h44);
        wait_ack(1, lat);
        check("mbusy_latency", lat, 3);
        check("mbusy_rd1",   rd_of(1),   32'hDEADBEEB);

        // ---- protocol errors: duplicate on core3, rd+wr on core1
        do_reset();
        mem_lat  = 4;
        base     = iss_addr.size();
        mem_busy = 1'b1;
        set_req(3, 1'b1, 1'b0, 32'h80, 32'h0);
        step();
        set_req(3, 1'b0, 1'b1, 32'h99, 32'h5555);
        set_req(1, 1'b1, 1'b1, 32'h90, 32'hCAFE0001);
        step();
        clear_req();
        mem_busy = 1'b0;
        check("err_flags",  err_dup,   4'b1010);
        check("err_busy",   core_busy, 4'b1010);
        wait_idle("err_done");
        check("err_ord0_addr", iss_addr[base+0], 32'h90);
        check("err_ord0_dir",  iss_wr[base+0],   1'b1);
        check("err_ord0_data", iss_data[base+0], 32'hCAFE0001);
        check("err_ord1_addr", iss_addr[base+1], 32'h80);
        check("err_ord1_dir",  iss_wr[base+1],   1'b0);
        check("err_rd3",    rd_of(3),  32'hDEADBE2F);
        check("err_rd1",    rd_of(1),  32'h0);
        check("err_sticky", err_dup,   4'b1010);

        // ---- reset in the middle of WAIT, then a stray mem_ack
        mem_lat = 10;
        set_req(2, 1'b1, 1'b0, 32'h50, 32'h0);
        step();
        clear_req();
        step();
        check("rw_issue",  mem_rd_req, 1'b1);
        step();
        check("rw_wait_addr", mem_addr,  32'h50);
        check("rw_wait_busy", core_busy, 4'b0100);
        auto_resp = 1'b0;
        rst       = 1'b0;
        #1;
        check("rw_busy",   core_busy,    4'h0);
        check("rw_ack",    core_ack,     4'h0);
        check("rw_err",    err_dup,      4'h0);
        check("rw_rdreq",  mem_rd_req,   1'b0);
        check("rw_wrreq",  mem_wr_req,   1'b0);
        check("rw_addr",   mem_addr,     32'h0);
        check("rw_wdata",  mem_wr_data,  32'h0);
        check("rw_rdata",  core_rd_data, 128'h0);
        step();
        rst  = 1'b1;
        ack0 = ack_total;
        step();
        mem_ack_man = 1'b1;
        step();
        mem_ack_man = 1'b0;
        check("rw_stray_ack0", core_ack, 4'h0);
        step();
        check("rw_stray_ack1", core_ack, 4'h0);
        step();
        check("rw_stray_cnt",  ack_total - ack0, 0);
        check("rw_stray_busy", core_busy, 4'h0);
        check("rw_stray_req",  mem_rd_req | mem_wr_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
